// File: rtl/decode_pkg.sv
// Shared opcodes, format codes and the per-entry decode bundle
// used by the RV32I/RV64I decode stage.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_R32    = 7'b0111011;

    // Widest case; the stage slices these down to its XLEN.
    localparam int IMM_W = 64;
    localparam int RS2_W = 6;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [4:0]       rs1;
        logic [RS2_W-1:0] rs2;
        logic [4:0]       rd;
        logic [3:0]       alu_func;
        logic [IMM_W-1:0] imm;
        fmt_e             fmt;
        logic             illegal;
    } decoded_t;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational field extraction and legality check for one
// 32-bit RV32I/RV64I instruction word.
module inst_field_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] inst_i,
    output decoded_t    dec_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  shamt;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] imm_j;
    logic [63:0] imm_u;
    logic        sh_zero;
    logic        sh_alt;
    logic        w_zero;
    logic        w_alt;
    logic        ill;
    decoded_t    d;

    assign op    = inst_i[6:0];
    assign f3    = inst_i[14:12];
    assign f7    = inst_i[31:25];
    assign rs1   = inst_i[19:15];
    assign rs2   = inst_i[24:20];
    assign rd    = inst_i[11:7];
    assign shamt = {inst_i[25] & RV64, inst_i[24:20]};

    assign imm_i = {{52{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{51{inst_i[31]}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_j = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12],
                    inst_i[20], inst_i[30:21], 1'b0};
    assign imm_u = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};

    // On RV64 bit 25 belongs to the shamt, so only [31:26] qualify.
    always_comb begin
        if (RV64) begin
            sh_zero = (inst_i[31:26] == 6'b000000);
            sh_alt  = (inst_i[31:26] == 6'b010000);
        end else begin
            sh_zero = (f7 == 7'b0000000);
            sh_alt  = (f7 == 7'b0100000);
        end
    end

    assign w_zero = (f7 == 7'b0000000);
    assign w_alt  = (f7 == 7'b0100000);

    always_comb begin
        d        = '0;
        d.opcode = op;
        d.fmt    = FMT_ILL;
        ill      = 1'b0;
        case (op)
            OP_R, OP_R32: begin
                d.fmt      = FMT_R;
                d.rs1      = rs1;
                d.rs2      = {1'b0, rs2};
                d.rd       = rd;
                d.alu_func = {inst_i[30], f3};
                if (f7 == 7'b0100000) begin
                    ill = !(f3 == 3'b000 || f3 == 3'b101);
                end else begin
                    ill = (f7 != 7'b0000000);
                end
                if (op == OP_R32 && !RV64) begin
                    ill = 1'b1;
                end
            end
            OP_IMM, OP_IMM32: begin
                d.fmt      = FMT_I;
                d.rs1      = rs1;
                d.rd       = rd;
                d.imm      = imm_i;
                d.alu_func = {1'b0, f3};
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.alu_func[3] = inst_i[30] & f3[2];
                    if (op == OP_IMM) begin
                        d.rs2 = shamt;
                        ill = f3[2] ? !(sh_zero || sh_alt) : !sh_zero;
                    end else begin
                        d.rs2 = {1'b0, rs2};
                        ill = f3[2] ? !(w_zero || w_alt) : !w_zero;
                    end
                end
                if (op == OP_IMM32 && !RV64) begin
                    ill = 1'b1;
                end
            end
            OP_LOAD, OP_JALR: begin
                d.fmt      = FMT_I;
                d.rs1      = rs1;
                d.rd       = rd;
                d.imm      = imm_i;
                d.alu_func = {1'b0, f3};
                if (op == OP_JALR) begin
                    ill = (f3 != 3'b000);
                end else begin
                    ill = (f3 == 3'b111) ||
                          (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
                end
            end
            OP_STORE: begin
                d.fmt      = FMT_S;
                d.rs1      = rs1;
                d.rs2      = {1'b0, rs2};
                d.imm      = imm_s;
                d.alu_func = {1'b0, f3};
                ill = f3[2] || (!RV64 && f3 == 3'b011);
            end
            OP_BRANCH: begin
                d.fmt      = FMT_B;
                d.rs1      = rs1;
                d.rs2      = {1'b0, rs2};
                d.imm      = imm_b;
                d.alu_func = {1'b0, f3};
                ill = (f3 == 3'b010 || f3 == 3'b011);
            end
            OP_JAL: begin
                d.fmt = FMT_J;
                d.rd  = rd;
                d.imm = imm_j;
            end
            OP_LUI, OP_AUIPC: begin
                d.fmt = FMT_U;
                d.rd  = rd;
                d.imm = imm_u;
            end
            default: begin
                ill = 1'b1;
            end
        endcase
        if (inst_i[1:0] != 2'b11) begin
            ill = 1'b1;
        end
        if (ill) begin
            d.rs1      = '0;
            d.rs2      = '0;
            d.rd       = '0;
            d.alu_func = '0;
            d.imm      = '0;
            d.fmt      = FMT_ILL;
        end
        d.illegal = ill;
    end

    assign dec_o = d;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main/skid entry pair behind a
// valid/ready handshake with a registered in_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [6:0]         out_opcode,
    output logic [4:0]         out_rs1,
    output logic [SHAMT_W-1:0] out_rs2,
    output logic [4:0]         out_rd,
    output logic [3:0]         out_alu_func,
    output logic [XLEN-1:0]    out_imm,
    output fmt_e               out_fmt,
    output logic               out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        decoded_t        dec;
    } entry_t;

    decoded_t dec;
    entry_t   in_e;
    entry_t   main_d;
    entry_t   main_q;
    entry_t   skid_d;
    entry_t   skid_q;
    logic     main_v_d;
    logic     main_v_q;
    logic     skid_v_d;
    logic     skid_v_q;
    logic     in_fire;
    logic     drain;
    logic     unused_bits;

    inst_field_decode #(
        .XLEN (XLEN)
    ) u_fields (
        .inst_i (in_inst),
        .dec_o  (dec)
    );

    assign in_e     = '{pc: in_pc, dec: dec};
    assign in_ready = !skid_v_q;
    assign in_fire  = in_valid & in_ready;
    assign drain    = !main_v_q | out_ready;

    // in_ready is low whenever skid is occupied, so a refill from
    // skid never coincides with a new acceptance.
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (drain) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) begin
                    main_d = in_e;
                end
            end
        end else if (in_fire) begin
            skid_d   = in_e;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign out_valid    = main_v_q;
    assign out_pc       = main_q.pc;
    assign out_opcode   = main_q.dec.opcode;
    assign out_rs1      = main_q.dec.rs1;
    assign out_rs2      = main_q.dec.rs2[SHAMT_W-1:0];
    assign out_rd       = main_q.dec.rd;
    assign out_alu_func = main_q.dec.alu_func;
    assign out_imm      = main_q.dec.imm[XLEN-1:0];
    assign out_fmt      = main_q.dec.fmt;
    assign out_illegal  = main_q.dec.illegal;

    assign unused_bits = ^{main_q.dec.imm, main_q.dec.rs2};

endmodule
